uart_tx_buffer: RTL and testbench

- Upstream feeder for the UART transmitter FSM/serializer. Accepts parallel bytes from the system side into a small synchronous FIFO.
- Issues one byte at a time to the transmitter as a single-cycle DATA_VALID pulse with P_DATA. It then tracks the transmitter's BUSY through one complete frame before issuing the next byte.
- Decouples bursty producers from the bit-rate-limited UART TX path.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_mem.sv | 82 ++++++++
 rtl/uart_tx_buffer.sv | 128 ++++++++++++
 tb/tb_uart_tx_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART transmit buffer.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } e_buf_states;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_BUF_DEPTH  = 8;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte FIFO for the UART transmit buffer: an input capture stage, storage, and registered occupancy.
// FULL counts the write still in the capture stage, so an accepted byte always has a free slot.
module uart_tx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_vld_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;
    logic                  wr_acc;
    logic                  pop;
    logic [CW-1:0]         count_nxt;

    assign wr_acc  = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_vld_p0 && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!wr_vld_p0 && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Stage p0: capture the accepted write
    always_ff @(posedge clk) begin
        wr_data_p0 <= wr_data;
        if (rst) begin
            wr_vld_p0 <= 1'b0;
        end else begin
            wr_vld_p0 <= wr_acc;
        end
    end

    // Stage p1: commit to storage and update occupancy
    always_ff @(posedge clk) begin
        if (wr_vld_p0 && !rst) begin
            mem[wr_ptr] <= wr_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_vld_p0) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= ((count_nxt + CW'(wr_acc)) == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Feeds the UART transmitter one byte per frame from a small FIFO.
// Define UART_TX_BUF_OVERFLOW_EN to add the sticky OVERFLOW and TIMEOUT_ERR outputs.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int DEPTH        = UART_BUF_DEPTH,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    WR_DATA,
    input  logic                     WR_EN,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    input  logic                     BUSY,
    output logic [DATA_WIDTH-1:0]    P_DATA,
    output logic                     DATA_VALID
`ifdef UART_TX_BUF_OVERFLOW_EN
    ,
    output logic                     OVERFLOW,
    output logic                     TIMEOUT_ERR
`endif
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    e_buf_states           state;
    e_buf_states           state_nxt;
    logic [TW-1:0]         tmo_cnt;
    logic [TW-1:0]         tmo_nxt;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
`ifdef UART_TX_BUF_OVERFLOW_EN
    logic                  tmo_fire;
`endif

    uart_tx_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_data(WR_DATA),
        .wr_en  (WR_EN),
        .rd_en  (pop),
        .rd_data(head),
        .count  (COUNT),
        .full   (FULL),
        .empty  (EMPTY)
    );

    always_comb begin
        state_nxt  = state;
        tmo_nxt    = tmo_cnt;
        pop        = 1'b0;
        DATA_VALID = 1'b0;
`ifdef UART_TX_BUF_OVERFLOW_EN
        tmo_fire   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!EMPTY && !BUSY) begin
                    state_nxt = ISSUE;
                    pop       = 1'b1;
                end
            end
            ISSUE: begin
                DATA_VALID = 1'b1;
                tmo_nxt    = '0;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (BUSY) begin
                    state_nxt = WAIT_DONE;
                    tmo_nxt   = '0;
                end else if ((tmo_cnt + TW'(1)) == TW'(BUSY_TIMEOUT)) begin
                    // Transmitter never took the byte; it is dropped.
                    state_nxt = IDLE;
                    tmo_nxt   = '0;
`ifdef UART_TX_BUF_OVERFLOW_EN
                    tmo_fire  = 1'b1;
`endif
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!BUSY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            P_DATA  <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            if (pop) begin
                P_DATA <= head;
            end
        end
    end

`ifdef UART_TX_BUF_OVERFLOW_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            if (WR_EN && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (tmo_fire) begin
                TIMEOUT_ERR <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue scoreboard of accepted bytes plus a BUSY responder.
module tb_uart_tx_buffer;

    localparam int DEPTH = 8;
    localparam int TMO   = 4;

    logic       CLK_tb = 1'b0;
    logic       RST = 1'b0;
    logic       WR_EN = 1'b0;
    logic       BUSY = 1'b0;
    logic [7:0] WR_DATA = 8'h00;
    logic [7:0] P_DATA;
    logic       FULL;
    logic       EMPTY;
    logic       DATA_VALID;
    logic [3:0] COUNT;
`ifdef UART_TX_BUF_OVERFLOW_EN
    logic       OVERFLOW;
    logic       TIMEOUT_ERR;
`endif

    always #5 CLK_tb = ~CLK_tb;

    uart_tx_buffer #(
        .DATA_WIDTH  (8),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .CLK       (CLK_tb),
        .RST       (RST),
        .WR_DATA   (WR_DATA),
        .WR_EN     (WR_EN),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .BUSY      (BUSY),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID)
`ifdef UART_TX_BUF_OVERFLOW_EN
        ,
        .OVERFLOW   (OVERFLOW),
        .TIMEOUT_ERR(TIMEOUT_ERR)
`endif
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pdata_model = 8'h00;
    int         dv_cycles[$];
    logic       dv_prev = 1'b0;
    int         busy_len = 0;
    int         busy_rem = 0;
    logic       busy_force = 1'b0;
    logic       model_busy = 1'b0;
    logic       start_next = 1'b0;
    logic       saw_full = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         busy_len;
        int         exp_lat;
        int         exp_pulses;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample outputs after the edge, score any issue, then update the BUSY responder.
    task automatic step();
        @(posedge CLK_tb);
        #1;
        cyc++;
        if (FULL) saw_full = 1'b1;
        if (DATA_VALID) begin
            dv_cycles.push_back(cyc);
            check("dv_single_cycle", 32'(dv_prev), 32'd0);
            check("dv_while_busy", 32'(BUSY), 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_dv", 32'(P_DATA), 32'h100);
            end else begin
                pdata_model = exp_q.pop_front();
                check("p_data_issue", 32'(P_DATA), 32'(pdata_model));
            end
        end else begin
            check("p_data_hold", 32'(P_DATA), 32'(pdata_model));
        end
        dv_prev = DATA_VALID;
        if (model_busy) begin
            busy_rem--;
            if (busy_rem == 0) model_busy = 1'b0;
        end
        if (start_next) begin
            model_busy = 1'b1;
            busy_rem   = busy_len;
            start_next = 1'b0;
        end
        if (DATA_VALID && busy_len > 0) start_next = 1'b1;
        BUSY = busy_force | model_busy;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input bit clear_busy);
        RST   = 1'b1;
        WR_EN = 1'b0;
        exp_q.delete();
        pdata_model = 8'h00;
        if (clear_busy) begin
            busy_force = 1'b0;
            model_busy = 1'b0;
            start_next = 1'b0;
            busy_rem   = 0;
            BUSY       = 1'b0;
        end
        step();
        RST = 1'b0;
    endtask

    task automatic write(input logic [7:0] b, input bit acc);
        WR_EN   = 1'b1;
        WR_DATA = b;
        if (acc) exp_q.push_back(b);
        step();
        WR_EN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         wcyc;
        int         sent;
        int         guard;
        logic [7:0] rb;

        vecs[0] = '{data: 8'hA5, busy_len: 10, exp_lat: 3, exp_pulses: 1, exp_count: 4'd0};
        vecs[1] = '{data: 8'h00, busy_len: 1,  exp_lat: 3, exp_pulses: 1, exp_count: 4'd0};
        vecs[2] = '{data: 8'hFF, busy_len: 5,  exp_lat: 3, exp_pulses: 1, exp_count: 4'd0};
        vecs[3] = '{data: 8'h5A, busy_len: 2,  exp_lat: 3, exp_pulses: 1, exp_count: 4'd0};

        // Reset state
        do_reset(1'b1);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_dv", 32'(DATA_VALID), 32'd0);
        check("rst_p_data", 32'(P_DATA), 32'd0);

        // Single-byte frames with different BUSY lengths
        for (int i = 0; i < 4; i++) begin
            busy_len = vecs[i].busy_len;
            do_reset(1'b1);
            dv_cycles.delete();
            write(vecs[i].data, 1'b1);
            wcyc = cyc;
            idle(30);
            check("vec_pulses", 32'(dv_cycles.size()), 32'(vecs[i].exp_pulses));
            check("vec_latency", (dv_cycles.size() > 0) ? 32'(dv_cycles[0] - wcyc + 1) : 32'd0,
                  32'(vecs[i].exp_lat));
            check("vec_count", 32'(COUNT), 32'(vecs[i].exp_count));
            check("vec_empty", 32'(EMPTY), 32'd1);
            check("vec_drained", 32'(exp_q.size()), 32'd0);
        end

        // Fill while the transmitter is busy, overflow attempt, then drain in order
        busy_len = 3;
        do_reset(1'b1);
        dv_cycles.delete();
        busy_force = 1'b1;
        BUSY = 1'b1;
        step();
        for (int b = 1; b <= DEPTH; b++) write(8'(b), 1'b1);
        idle(2);
        check("burst_full", 32'(FULL), 32'd1);
        check("burst_count", 32'(COUNT), 32'(DEPTH));
        check("burst_no_issue", 32'(dv_cycles.size()), 32'd0);
        write(8'hFF, 1'b0);
        idle(2);
        check("ovf_count", 32'(COUNT), 32'(DEPTH));
        check("ovf_full", 32'(FULL), 32'd1);
`ifdef UART_TX_BUF_OVERFLOW_EN
        check("ovf_flag", 32'(OVERFLOW), 32'd1);
`endif
        busy_force = 1'b0;
        idle(DEPTH * 8 + 10);
        check("burst_issued", 32'(dv_cycles.size()), 32'(DEPTH));
        check("burst_drained", 32'(exp_q.size()), 32'd0);
        check("burst_count_end", 32'(COUNT), 32'd0);

        // BUSY never rises: byte is abandoned after the timeout, next byte follows
        busy_len = 0;
        do_reset(1'b1);
        dv_cycles.delete();
        write(8'h3C, 1'b1);
        idle(2);
        write(8'h5A, 1'b1);
        idle(20);
        check("tmo_pulses", 32'(dv_cycles.size()), 32'd2);
        check("tmo_spacing", (dv_cycles.size() > 1) ? 32'(dv_cycles[1] - dv_cycles[0]) : 32'd0,
              32'(TMO + 2));
        check("tmo_count", 32'(COUNT), 32'd0);
`ifdef UART_TX_BUF_OVERFLOW_EN
        check("tmo_flag", 32'(TIMEOUT_ERR), 32'd1);
`endif

        // Reset while a frame is in flight with bytes queued
        busy_len = 10;
        do_reset(1'b1);
        dv_cycles.delete();
        write(8'h11, 1'b1);
        write(8'h22, 1'b1);
        write(8'h33, 1'b1);
        write(8'h44, 1'b1);
        idle(3);
        check("mid_queued", 32'(COUNT), 32'd3);
        do_reset(1'b0);
        check("mid_rst_count", 32'(COUNT), 32'd0);
        check("mid_rst_empty", 32'(EMPTY), 32'd1);
        check("mid_rst_dv", 32'(DATA_VALID), 32'd0);
        check("mid_rst_p_data", 32'(P_DATA), 32'd0);
        dv_cycles.delete();
        idle(25);
        check("mid_no_issue", 32'(dv_cycles.size()), 32'd0);

        // Random bytes written while draining, enough to wrap the pointers
        busy_len = 3 + int'($urandom_range(0, 1));
        do_reset(1'b1);
        dv_cycles.delete();
        saw_full = 1'b0;
        sent = 0;
        guard = 0;
        while (sent < 12 && guard < 500) begin
            if (!FULL) begin
                rb = 8'($urandom);
                write(rb, 1'b1);
                sent++;
            end else begin
                step();
            end
            guard++;
        end
        check("wrap_sent", 32'(sent), 32'd12);
        idle(200);
        check("wrap_full_seen", 32'(saw_full), 32'd1);
        check("wrap_issued", 32'(dv_cycles.size()), 32'd12);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_count", 32'(COUNT), 32'd0);
        check("wrap_empty", 32'(EMPTY), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
